// File: rtl/mem_responder_if.sv
// Request/response bundle between the fetch/memory-access stages and the memory responder.
// Handshake: a request is taken on a rising edge where enable=1 and busy=0; enable while busy is dropped.
interface mem_responder_if;
   logic [31:0] address;
   logic        rw;
   logic [31:0] access_size;
   logic        enable;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        err;

   modport master (
      output address, rw, access_size, enable, data_in,
      input  data_out, data_valid, busy, err
   );

   modport slave (
      input  address, rw, access_size, enable, data_in,
      output data_out, data_valid, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed, word-organised main memory serving single-word and burst reads/writes.
// Handshake: request taken when enable=1 and busy=0; read beats flagged by data_valid; err pulses on rejects.
module mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h80020000,
   parameter int          DEPTH_WORDS = 262144
) (
   input  logic             clock,
   input  logic             reset,
   mem_responder_if.slave   bus,
   output logic [1:0]       dbg_state
);

   localparam int          IW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      beat_q, beat_d;
   logic [3:0]      last_q, last_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [31:0]     data_out_q, data_out_d;
   logic            data_valid_q, data_valid_d;
   logic            err_q, err_d;

   logic [31:0]     mem [DEPTH_WORDS];

   logic [31:0]     req_off;
   logic [32:0]     req_end;
   logic            size_ok;
   logic            req_ok;
   logic [IW-1:0]   req_idx;
   logic [3:0]      req_last;

   logic            mem_we;
   logic [IW-1:0]   mem_widx;

   // Range check in 33 bits so an end address past 4 GB cannot wrap back into range.
   always_comb begin
      req_off  = bus.address - BASE_ADDR;
      req_end  = {1'b0, req_off} + {1'b0, bus.access_size};
      size_ok  = (bus.access_size == 32'd4)  || (bus.access_size == 32'd16) ||
                 (bus.access_size == 32'd32) || (bus.access_size == 32'd64);
      req_ok   = (bus.address[1:0] == 2'b00) && size_ok &&
                 (bus.address >= BASE_ADDR) && (req_end <= MEM_BYTES);
      req_idx  = req_off[IW+1:2];
      req_last = 4'((bus.access_size >> 2) - 32'd1);
   end

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      last_d       = last_q;
      idx_d        = idx_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               if (!req_ok) begin
                  err_d = 1'b1;
               end else if (bus.rw) begin
                  state_d      = RD_BURST;
                  beat_d       = 4'd0;
                  last_d       = req_last;
                  idx_d        = req_idx;
                  data_out_d   = mem[req_idx];
                  data_valid_d = 1'b1;
               end else if (req_last != 4'd0) begin
                  // Beat 0 is written on the accepting edge; the burst covers beats 1..N-1.
                  state_d = WR_BURST;
                  beat_d  = 4'd1;
                  last_d  = req_last;
                  idx_d   = req_idx + IW'(1);
               end
            end
         end
         RD_BURST: begin
            if (beat_q == last_q) begin
               state_d = IDLE;
            end else begin
               beat_d       = beat_q + 4'd1;
               idx_d        = idx_q + IW'(1);
               data_out_d   = mem[idx_q + IW'(1)];
               data_valid_d = 1'b1;
            end
         end
         WR_BURST: begin
            if (beat_q == last_q) begin
               state_d = IDLE;
            end else begin
               beat_d = beat_q + 4'd1;
               idx_d  = idx_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset blocks the write port so a request coinciding with reset leaves memory untouched.
   always_comb begin
      mem_we   = 1'b0;
      mem_widx = req_idx;
      if (!reset) begin
         if (state_q == WR_BURST) begin
            mem_we   = 1'b1;
            mem_widx = idx_q;
         end else if ((state_q == IDLE) && bus.enable && req_ok && !bus.rw) begin
            mem_we   = 1'b1;
            mem_widx = req_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         beat_q       <= 4'd0;
         last_q       <= 4'd0;
         idx_q        <= '0;
         data_out_q   <= 32'd0;
         data_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         last_q       <= last_d;
         idx_q        <= idx_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         err_q        <= err_d;
      end
   end

   // Storage is never cleared; contents survive reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_widx] <= bus.data_in;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.err        = err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed sequences, a vector table of request checks,
// and randomized traffic compared every cycle against a transaction-level memory model.
module tb_mem_responder;

   localparam logic [31:0] BASE      = 32'h80020000;
   localparam int          DEPTH     = 262144;
   localparam longint      MEM_BYTES = 64'(DEPTH) * 4;
   localparam logic [31:0] LAST_WORD = BASE + 32'(MEM_BYTES) - 32'd4;
   localparam logic [31:0] RAND_BASE = BASE + 32'h800;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] dbg_state;

   mem_responder_if bus_if();

   mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus_if),
      .dbg_state (dbg_state)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: sparse word memory plus the queue of read beats still to be shown.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] rd_q[$];
   logic [31:0] got_q[$];
   int unsigned wr_rem = 0;
   int unsigned widx   = 0;
   logic        m_valid = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_err   = 1'b0;
   logic [31:0] m_dout  = 32'd0;
   logic [31:0] wbuf [16];

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] size;
      logic        exp_err;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit req_legal(input logic [31:0] a, input logic [31:0] s);
      if (a[1:0] != 2'b00) return 1'b0;
      if (!(s == 4 || s == 16 || s == 32 || s == 64)) return 1'b0;
      if (a < BASE) return 1'b0;
      return (longint'(a - BASE) + longint'(s)) <= MEM_BYTES;
   endfunction

   task automatic model_edge();
      int unsigned idx;
      if (reset) begin
         rd_q.delete();
         wr_rem  = 0;
         m_valid = 1'b0;
         m_busy  = 1'b0;
         m_err   = 1'b0;
         m_dout  = 32'd0;
         return;
      end
      m_err = 1'b0;
      if (wr_rem > 0) begin
         ref_mem[widx] = bus_if.data_in;
         widx++;
         wr_rem--;
      end else if (!m_busy && bus_if.enable) begin
         if (!req_legal(bus_if.address, bus_if.access_size)) begin
            m_err = 1'b1;
         end else begin
            idx = (bus_if.address - BASE) >> 2;
            if (bus_if.rw) begin
               for (int k = 0; k < int'(bus_if.access_size / 4); k++)
                  rd_q.push_back(ref_mem.exists(idx + k) ? ref_mem[idx + k] : 32'hx);
            end else begin
               ref_mem[idx] = bus_if.data_in;
               wr_rem = bus_if.access_size / 4 - 1;
               widx   = idx + 1;
            end
         end
      end
      if (rd_q.size() > 0) begin
         m_dout  = rd_q.pop_front();
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      m_busy = m_valid || (wr_rem > 0);
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      cyc++;
      chk("data_valid", 32'(bus_if.data_valid), 32'(m_valid));
      chk("busy",       32'(bus_if.busy),       32'(m_busy));
      chk("err",        32'(bus_if.err),        32'(m_err));
      chk("data_out",   bus_if.data_out,        m_dout);
   endtask

   task automatic drive(input logic en, input logic rw_i, input logic [31:0] a,
                        input logic [31:0] s, input logic [31:0] d);
      bus_if.enable      = en;
      bus_if.rw          = rw_i;
      bus_if.address     = a;
      bus_if.access_size = s;
      bus_if.data_in     = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'($urandom), $urandom, $urandom, $urandom);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] s);
      drive(1'b1, 1'b0, a, s, wbuf[0]);
      tick();
      for (int k = 1; k < int'(s / 4); k++) begin
         drive(1'b0, 1'($urandom), $urandom, $urandom, wbuf[k]);
         tick();
      end
      idle();
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] s);
      got_q.delete();
      drive(1'b1, 1'b1, a, s, $urandom);
      tick();
      if (bus_if.data_valid) got_q.push_back(bus_if.data_out);
      idle();
      for (int k = 0; k < int'(s / 4); k++) begin
         tick();
         if (bus_if.data_valid) got_q.push_back(bus_if.data_out);
      end
   endtask

   initial begin
      int busy_cnt;
      int valid_cnt;
      logic [31:0] exp_w;

      reset = 1'b1;
      idle();
      repeat (3) tick();
      chk("reset_data_out", bus_if.data_out, 32'd0);
      reset = 1'b0;
      idle();
      tick();

      // Single write then single read at the base address.
      drive(1'b1, 1'b0, BASE, 32'd4, 32'hDEADBEEF);
      tick();
      chk("wr1_busy", 32'(bus_if.busy), 32'd0);
      drive(1'b1, 1'b1, BASE, 32'd4, 32'd0);
      tick();
      chk("rd1_data", bus_if.data_out, 32'hDEADBEEF);
      chk("rd1_valid", 32'(bus_if.data_valid), 32'd1);
      chk("rd1_busy", 32'(bus_if.busy), 32'd1);
      idle();
      tick();
      chk("rd1_valid_end", 32'(bus_if.data_valid), 32'd0);
      chk("rd1_busy_end", 32'(bus_if.busy), 32'd0);

      // Four-word write burst, busy for exactly three cycles, then read back.
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      busy_cnt = 0;
      drive(1'b1, 1'b0, BASE + 32'h10, 32'd16, wbuf[0]);
      tick();
      busy_cnt += int'(bus_if.busy);
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 1'b1, $urandom, $urandom, wbuf[k]);
         tick();
         busy_cnt += int'(bus_if.busy);
      end
      chk("wr4_busy_cycles", 32'(busy_cnt), 32'd3);
      idle();
      do_read(BASE + 32'h10, 32'd16);
      chk("rd4_beats", 32'(got_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < got_q.size(); k++)
         chk("rd4_data", got_q[k], 32'h11 * 32'(k + 1));

      // Preload 64 words used by the dropped-request test and the random phase.
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
         do_write(RAND_BASE + 32'(b * 64), 32'd64);
      end

      // 16-word read; a second request held from beat 3 is dropped until the burst ends.
      drive(1'b1, 1'b1, RAND_BASE, 32'd64, 32'd0);
      tick();
      valid_cnt = int'(bus_if.data_valid);
      for (int c = 1; c <= 17; c++) begin
         if (c >= 3) drive(1'b1, 1'b1, RAND_BASE + 32'h40, 32'd64, 32'd0);
         else        idle();
         tick();
         if (c + 1 <= 17) valid_cnt += int'(bus_if.data_valid);
      end
      chk("rd16_valid_cycles", 32'(valid_cnt), 32'd16);
      chk("reissue_first_valid", 32'(bus_if.data_valid), 32'd1);
      exp_w = ref_mem[(RAND_BASE + 32'h40 - BASE) >> 2];
      chk("reissue_first_data", bus_if.data_out, exp_w);
      idle();
      repeat (16) tick();

      // Request legality table: each rejected request pulses err for one cycle only.
      vecs[0] = '{1'b0, 32'h80020002, 32'd4, 1'b1};
      vecs[1] = '{1'b0, 32'h8001FFFC, 32'd4, 1'b1};
      vecs[2] = '{1'b0, BASE, 32'd8, 1'b1};
      vecs[3] = '{1'b1, LAST_WORD, 32'd16, 1'b1};
      vecs[4] = '{1'b0, LAST_WORD, 32'd4, 1'b0};
      vecs[5] = '{1'b0, LAST_WORD - 32'd12, 32'd32, 1'b1};
      vecs[6] = '{1'b0, 32'hFFFFFFFC, 32'd64, 1'b1};
      vecs[7] = '{1'b1, BASE, 32'd0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vecs[i].rw, vecs[i].addr, vecs[i].size, 32'hBAD0BAD0);
         tick();
         chk("vec_err", 32'(bus_if.err), 32'(vecs[i].exp_err));
         chk("vec_busy", 32'(bus_if.busy), 32'd0);
         idle();
         tick();
         chk("vec_err_pulse", 32'(bus_if.err), 32'd0);
      end
      do_read(BASE, 32'd4);
      chk("err_keep_base", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hDEADBEEF);
      do_read(BASE + 32'h10, 32'd4);
      chk("err_keep_base10", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h11);
      do_read(LAST_WORD, 32'd4);
      chk("last_word_write", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hBAD0BAD0);

      // Reset at beat 3 of an 8-word read aborts the burst.
      for (int k = 0; k < 8; k++) wbuf[k] = 32'hA5000000 + 32'(k);
      do_write(BASE + 32'h40, 32'd32);
      drive(1'b1, 1'b1, BASE + 32'h40, 32'd32, 32'd0);
      tick();
      idle();
      tick();
      tick();
      chk("pre_reset_beat3", bus_if.data_out, 32'hA5000002);
      reset = 1'b1;
      tick();
      chk("mid_reset_valid", 32'(bus_if.data_valid), 32'd0);
      chk("mid_reset_busy", 32'(bus_if.busy), 32'd0);
      chk("mid_reset_dout", bus_if.data_out, 32'd0);
      reset = 1'b0;
      drive(1'b1, 1'b1, BASE + 32'h44, 32'd4, 32'd0);
      tick();
      chk("post_reset_valid", 32'(bus_if.data_valid), 32'd1);
      chk("post_reset_data", bus_if.data_out, 32'hA5000001);
      idle();
      tick();

      // Back-to-back single writes on consecutive cycles never raise busy.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, BASE + 32'h100 + 32'(4 * i), 32'd4, 32'hC0DE0000 + 32'(i));
         tick();
         chk("b2b_busy", 32'(bus_if.busy), 32'd0);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         do_read(BASE + 32'h100 + 32'(4 * i), 32'd4);
         chk("b2b_readback", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hC0DE0000 + 32'(i));
      end

      // Random traffic inside the preloaded window, checked against the model each cycle.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] sz;
         logic [31:0] a;
         case ($urandom_range(0, 5))
            0: sz = 32'd4;
            1: sz = 32'd16;
            2: sz = 32'd32;
            3: sz = 32'd64;
            4: sz = 32'd4;
            default: sz = 32'd8;
         endcase
         a = RAND_BASE + 32'(4 * $urandom_range(0, 48));
         if ($urandom_range(0, 15) == 0) a = a + 32'd2;
         reset = ($urandom_range(0, 99) < 2);
         drive(1'($urandom_range(0, 2) != 0), 1'($urandom), a, sz, $urandom);
         tick();
      end
      reset = 1'b0;
      idle();
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the request interface driven by the fetch/memory-access stages: address, rw, access_size, enable in; data and status out.
- Models a byte-addressed, word-organised main memory mapped at the program base address.
- Serves single-word and burst reads and writes.
- Used as both instruction and data memory in the processor testbench.

Parameters:
- BASE_ADDR, 32'h80020000, first byte address served.
- DEPTH_WORDS, 262144, memory size in 32-bit words (1 MB).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- address  input  32  byte address of first beat
- rw  input  1  1 = read, 0 = write
- access_size  input  32  transfer size in bytes: 4, 16, 32 or 64 (1, 4, 8 or 16 words)
- enable  input  1  request strobe, sampled each rising edge
- data_in  input  32  write data, one word per beat
- data_out  output  32  read data
- data_valid  output  1  data_out holds a valid read beat
- busy  output  1  burst in progress; requests are dropped while high
- err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset (synchronous, active-high): state=IDLE, data_out=0, data_valid=0, busy=0, err=0, beat counter=0. Memory array contents are not cleared and persist across reset.
- Request acceptance:
  - Accepted at the rising edge where enable=1 and busy=0 (call this cycle T).
  - If enable=1 and busy=1, the request is ignored. No queueing. The requester must hold or reissue.
- Validity checks at acceptance:
  - address[1:0] must be 0.
  - access_size must be in {4,16,32,64}.
  - BASE_ADDR <= address.
  - (address-BASE_ADDR)+access_size <= DEPTH_WORDS*4. Use 33-bit arithmetic so overflow cannot wrap.
  - On any failure: err=1 for cycle T+1 only. No memory access. busy and data_valid stay 0.
- Word index: (address-BASE_ADDR)>>2. Beat k uses index+k. N = access_size/4.
- States: IDLE, RD_BURST, WR_BURST.
- Read, N beats:
  - IDLE -> RD_BURST at T.
  - In cycles T+1 .. T+N: data_out = mem[index+k-1] for k = 1..N, with data_valid=1 and busy=1.
  - After the edge ending T+N: IDLE, data_valid=0, busy=0, data_out holds its last value.
  - A request presented during T+N is dropped. The next request is accepted no earlier than the edge ending T+N+1.
- Write, N beats:
  - data_in with the request at T is written to mem[index] at the edge ending T.
  - If N>1: IDLE -> WR_BURST. busy=1 in cycles T+1 .. T+N-1. data_in sampled in cycle T+k is written to mem[index+k].
  - Return to IDLE after the last beat.
  - N=1: busy never asserts, and back-to-back single writes run every cycle.
  - data_valid is never asserted for writes.
- Beat counter is 4 bits, counting 0..N-1. No address wrap within a burst; the range check guarantees this.
- rw, address and access_size are ignored while busy. Only data_in matters during WR_BURST.
- Reset mid-burst: burst aborted at that edge. Beats already written remain. No further data_valid.
- Reset and enable in the same cycle: reset wins, request discarded.
- Read of a word not yet written returns X in simulation. The bench preloads by writes.

Test Plan:
- Reset, then single write address=0x80020000, data_in=0xDEADBEEF, access_size=4; then single read at the same address -> at T+1 data_out=0xDEADBEEF, data_valid=1, busy=1; both 0 at T+2.
- 4-word write burst at 0x80020010 with data 0x11,0x22,0x33,0x44 -> busy=1 for 3 cycles. A following 16-byte read -> data_out 0x11,0x22,0x33,0x44 on T+1..T+4, data_valid high exactly 4 cycles.
- Read burst of 16 words with a second request asserted during beats 3..16 -> second request dropped (no extra data_valid). Reissued at T+17 -> accepted, first beat at T+18.
- Error cases: address=0x80020002; address=0x8001FFFC; access_size=8; last-word overflow (address=BASE_ADDR+DEPTH_WORDS*4-4, size 16) -> err pulses 1 cycle each, busy=0, memory unchanged on readback.
- Reset asserted at beat 3 of an 8-word read -> next cycle data_valid=0, busy=0, data_out=0. A new read accepted the cycle after reset deasserts.
- Back-to-back single-word writes on 4 consecutive cycles to 0x80020100..0x8002010C -> all four words read back correctly, busy never asserted.
